// File: rtl/delay_scheduler_pkg.sv
// Shared types and default sizing for the delay scheduler and its slots.
package delay_scheduler_pkg;

  typedef enum logic [1:0] {
    FREE    = 2'd0,
    COUNT   = 2'd1,
    EXPIRED = 2'd2
  } slot_state_e;

  localparam int DEF_NUM_SLOTS = 4;
  localparam int DEF_DELAY_W   = 8;
  localparam int DEF_TAG_W     = 4;

endpackage

// File: rtl/delay_slot.sv
// One pending-event slot: FREE -> COUNT -> EXPIRED -> FREE with a down-counter and tag.
module delay_slot
  import delay_scheduler_pkg::*;
#(
  parameter int DELAY_W = DEF_DELAY_W,
  parameter int TAG_W   = DEF_TAG_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [DELAY_W-1:0] load_count,
  input  logic [TAG_W-1:0]   load_tag,
  input  logic               select,
  output slot_state_e        state,
  output logic [TAG_W-1:0]   tag
);

  slot_state_e        state_q, state_d;
  logic [DELAY_W-1:0] count_q, count_d;
  logic [TAG_W-1:0]   tag_q, tag_d;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    tag_d   = tag_q;
    case (state_q)
      FREE: begin
        if (load) begin
          state_d = COUNT;
          count_d = load_count;
          tag_d   = load_tag;
        end
      end
      COUNT: begin
        // Expire on the edge that would take the count from 1 to 0, so it never wraps.
        if (count_q == DELAY_W'(1)) state_d = EXPIRED;
        else                        count_d = count_q - DELAY_W'(1);
      end
      EXPIRED: begin
        if (select) state_d = FREE;
      end
      default: state_d = FREE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FREE;
      count_q <= '0;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      tag_q   <= tag_d;
    end
  end

  assign state = state_q;
  assign tag   = tag_q;

endmodule

// File: rtl/delay_scheduler.sv
// Multi-slot delay scheduler: allocates requests to free slots and fires expired slots in index order.
// Optional fired-event counter enabled by macro DELAY_SCHEDULER_STATS_EN.
module delay_scheduler
  import delay_scheduler_pkg::*;
#(
  parameter int NUM_SLOTS = DEF_NUM_SLOTS,
  parameter int DELAY_W   = DEF_DELAY_W,
  parameter int TAG_W     = DEF_TAG_W
) (
  input  logic               clk,
  input  logic               reset,
  // Request handshake: accepted on a rising edge where req_valid && req_ready and reset is low.
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [DELAY_W-1:0] req_delay,
  input  logic [TAG_W-1:0]   req_tag,
  output logic               out_valid,
  output logic [TAG_W-1:0]   out_tag,
  output logic               busy
`ifdef DELAY_SCHEDULER_STATS_EN
  ,
  output logic [15:0]        fired_count
`endif
);

  slot_state_e          slot_state [NUM_SLOTS];
  logic [TAG_W-1:0]     slot_tag   [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] free_vec, exp_vec;
  logic [NUM_SLOTS-1:0] free_onehot, sel_vec, load_vec;
  logic [DELAY_W-1:0]   load_count;
  logic                 accept;

  logic                 out_valid_q, out_valid_d;
  logic [TAG_W-1:0]     out_tag_q, out_tag_d;

  always_comb begin
    free_vec = '0;
    exp_vec  = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      free_vec[i] = (slot_state[i] == FREE);
      exp_vec[i]  = (slot_state[i] == EXPIRED);
    end
  end

  // Isolate the lowest set bit: lowest-index free slot and lowest-index expired slot.
  assign free_onehot = free_vec & (~free_vec + NUM_SLOTS'(1));
  assign sel_vec     = exp_vec  & (~exp_vec  + NUM_SLOTS'(1));

  assign req_ready  = |free_vec;
  assign busy       = ~(&free_vec);
  assign accept     = req_valid & req_ready & ~reset;
  assign load_vec   = accept ? free_onehot : '0;
  assign load_count = (req_delay == '0) ? DELAY_W'(1) : req_delay;

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
    delay_slot #(
      .DELAY_W (DELAY_W),
      .TAG_W   (TAG_W)
    ) u_slot (
      .clk        (clk),
      .reset      (reset),
      .load       (load_vec[g]),
      .load_count (load_count),
      .load_tag   (req_tag),
      .select     (sel_vec[g]),
      .state      (slot_state[g]),
      .tag        (slot_tag[g])
    );
  end

  always_comb begin
    out_valid_d = |exp_vec;
    out_tag_d   = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (sel_vec[i]) out_tag_d = out_tag_d | slot_tag[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_tag_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_tag_q   <= out_tag_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_tag   = out_tag_q;

`ifdef DELAY_SCHEDULER_STATS_EN
  logic [15:0] fired_count_q, fired_count_d;

  always_comb begin
    fired_count_d = fired_count_q;
    if (out_valid_d && (fired_count_q != 16'hFFFF)) fired_count_d = fired_count_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) fired_count_q <= '0;
    else       fired_count_q <= fired_count_d;
  end

  assign fired_count = fired_count_q;
`endif

endmodule
